// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_pkg
// Brief  : Shared datapath width, operation/state encodings and shift helpers.
// Rev    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_JAL  = 4'b0011,
      OP_SLT  = 4'b0100,
      OP_XOR  = 4'b0101,
      OP_SUB  = 4'b0110,
      OP_JALR = 4'b0111,
      OP_BEQ  = 4'b1000,
      OP_BNE  = 4'b1001,
      OP_BLT  = 4'b1010,
      OP_BGE  = 4'b1011,
      OP_RSVD = 4'b1100,
      OP_SLL  = 4'b1101,
      OP_SRL  = 4'b1110,
      OP_SRA  = 4'b1111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   function automatic logic is_shift(input op_e op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

   // One bit of shift per call; SRA keeps replicating the sign bit.
   function automatic logic [DATA_W-1:0] shift_step(input op_e op, input logic [DATA_W-1:0] v);
      case (op)
         OP_SLL:  return {v[DATA_W-2:0], 1'b0};
         OP_SRL:  return {1'b0, v[DATA_W-1:1]};
         default: return {v[DATA_W-1], v[DATA_W-1:1]};
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// ============================================================================
// Module : alu_comb
// Brief  : Single-cycle ALU operations and branch/jump condition.
// Rev    : 1.0 - initial release
// ============================================================================
module alu_comb
   import alu_pkg::*;
(
   input  op_e               i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_result,
   output logic              o_taken
);

   logic [DATA_W-1:0] w_sum;
   logic [DATA_W-1:0] w_diff;
   logic              w_lt;
   logic              w_eq;

   assign w_sum  = i_a + i_b;
   assign w_diff = i_a - i_b;
   assign w_lt   = $signed(i_a) < $signed(i_b);
   assign w_eq   = (i_a == i_b);

   // Shift ops are resolved by the sequential shifter, so they yield zero here.
   always_comb begin
      o_result = '0;
      o_taken  = 1'b0;
      case (i_op)
         OP_AND:  o_result = i_a & i_b;
         OP_OR:   o_result = i_a | i_b;
         OP_ADD:  o_result = w_sum;
         OP_JAL:  o_taken  = 1'b1;
         OP_SLT:  o_result = {{(DATA_W-1){1'b0}}, w_lt};
         OP_XOR:  o_result = i_a ^ i_b;
         OP_SUB:  o_result = w_diff;
         OP_JALR: begin
            o_result = w_sum & ~{{(DATA_W-1){1'b0}}, 1'b1};
            o_taken  = 1'b1;
         end
         OP_BEQ:  o_taken  = w_eq;
         OP_BNE:  o_taken  = ~w_eq;
         OP_BLT:  o_taken  = w_lt;
         OP_BGE:  o_taken  = ~w_lt;
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module : alu_exec_unit
// Brief  : Handshaked ALU with multi-cycle bit-serial shifter and held result.
// Rev    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int DATA_W = alu_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        Operation,
   input  logic [DATA_W-1:0] SrcA,
   input  logic [DATA_W-1:0] SrcB,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] ALUResult,
   output logic              Taken
);

   state_e            r_state;
   op_e               r_op;
   logic [DATA_W-1:0] r_a;
   logic [4:0]        r_cnt;
   logic [DATA_W-1:0] r_result;
   logic              r_taken;

   op_e               w_op;
   logic [4:0]        w_shamt;
   logic              w_accept;
   logic [DATA_W-1:0] w_comb_result;
   logic              w_comb_taken;
   logic [DATA_W-1:0] w_step;

   assign w_op     = op_e'(Operation);
   assign w_shamt  = SrcB[4:0];
   assign w_accept = in_valid && in_ready && !flush;
   assign w_step   = shift_step(r_op, r_a);

   alu_comb u_alu_comb (
      .i_op     (w_op),
      .i_a      (SrcA),
      .i_b      (SrcB),
      .o_result (w_comb_result),
      .o_taken  (w_comb_taken)
   );

   // Handshake outputs are gated by rst_n so nothing is offered while in reset.
   assign in_ready  = rst_n && (r_state == ST_IDLE);
   assign out_valid = rst_n && (r_state == ST_DONE);
   assign ALUResult = r_result;
   assign Taken     = r_taken;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_op     <= OP_AND;
         r_a      <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_taken  <= 1'b0;
      end else if (flush) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op  <= w_op;
                  r_a   <= SrcA;
                  r_cnt <= w_shamt;
                  if (is_shift(w_op) && (w_shamt != 5'd0)) begin
                     r_state <= ST_SHIFT;
                  end else begin
                     r_state  <= ST_DONE;
                     r_result <= is_shift(w_op) ? SrcA : w_comb_result;
                     r_taken  <= w_comb_taken;
                  end
               end
            end
            ST_SHIFT: begin
               r_a   <= w_step;
               r_cnt <= r_cnt - 5'd1;
               // Last step writes the result directly so DONE follows after exactly k cycles.
               if (r_cnt == 5'd1) begin
                  r_state  <= ST_DONE;
                  r_result <= w_step;
                  r_taken  <= 1'b0;
               end
            end
            ST_DONE: begin
               if (out_ready) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_exec_unit
// Brief  : Scoreboard bench for alu_exec_unit with directed vectors.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  Operation;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUResult;
   logic        Taken;

   typedef struct {
      logic [31:0] res;
      logic        taken;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   first_cyc = 0;
   logic prev_v = 1'b0;

   alu_exec_unit #(.DATA_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Operation (Operation),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUResult (ALUResult),
      .Taken     (Taken)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops and compares on every output handshake.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid === 1'b1 && prev_v !== 1'b1) first_cyc = cyc;
      prev_v = out_valid;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("result", ALUResult, e.res);
            chk("taken", {31'd0, Taken}, {31'd0, e.taken});
            chk("latency", first_cyc, e.cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic et, input int lat, input bit push);
      bit got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         if (in_ready === 1'b1) got = 1'b1;
         else step();
      end
      if (!got) begin
         chk("issue_ready_timeout", {31'd0, in_ready}, 32'd1);
         return;
      end
      in_valid  = 1'b1;
      Operation = op;
      SrcA      = a;
      SrcB      = b;
      if (push) sb.push_back('{er, et, cyc + lat});
      step();
      in_valid  = 1'b0;
      Operation = 4'b0110;
      SrcA      = 32'hDEADBEEF;
      SrcB      = 32'h0000001F;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         if (sb.size() == 0 && in_ready === 1'b1) done = 1'b1;
         else step();
      end
      if (!done) chk("drain_timeout", sb.size(), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      Operation = 4'd0; SrcA = 32'd0; SrcB = 32'd0;
      step(); step();
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", ALUResult, 32'd0);
      chk("rst_taken", {31'd0, Taken}, 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Directed vectors: op, A, B, expected result, expected taken, latency
      issue(4'b0010, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1,  1'b1); // ADD wrap
      issue(4'b1111, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 32, 1'b1); // SRA 31
      issue(4'b1101, 32'h12345678, 32'd0,        32'h12345678, 1'b0, 1,  1'b1); // SLL 0
      issue(4'b1010, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b1, 1,  1'b1); // BLT
      issue(4'b1011, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0, 1,  1'b1); // BGE
      issue(4'b0100, 32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b0, 1,  1'b1); // SLT
      issue(4'b0110, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1,  1'b1); // SUB
      issue(4'b0101, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1'b0, 1,  1'b1); // XOR
      issue(4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1,  1'b1); // AND
      issue(4'b0001, 32'h0F000000, 32'h000000F0, 32'h0F0000F0, 1'b0, 1,  1'b1); // OR
      issue(4'b0011, 32'h11111111, 32'h22222222, 32'h00000000, 1'b1, 1,  1'b1); // JAL
      issue(4'b1000, 32'd3,        32'd3,        32'h00000000, 1'b1, 1,  1'b1); // BEQ
      issue(4'b1001, 32'd3,        32'd3,        32'h00000000, 1'b0, 1,  1'b1); // BNE
      issue(4'b1100, 32'd5,        32'd6,        32'h00000000, 1'b0, 1,  1'b1); // reserved
      issue(4'b1110, 32'hF0000000, 32'd4,        32'h0F000000, 1'b0, 5,  1'b1); // SRL 4
      issue(4'b1101, 32'h00000001, 32'd31,       32'h80000000, 1'b0, 32, 1'b1); // SLL 31
      issue(4'b1111, 32'h80000010, 32'd4,        32'hF8000001, 1'b0, 5,  1'b1); // SRA 4
      issue(4'b1110, 32'hCAFEF00D, 32'h00000020, 32'hCAFEF00D, 1'b0, 1,  1'b1); // SRL amt 0
      wait_idle();

      // Back-pressure: result must hold while out_ready is low
      out_ready = 1'b0;
      issue(4'b0010, 32'd10, 32'd20, 32'd30, 1'b0, 1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_result", ALUResult, 32'd30);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         step();
      end
      out_ready = 1'b1;
      step();
      chk("release_idle", {31'd0, in_ready}, 32'd1);

      // Flush in the third shift cycle of SRL k=10
      issue(4'b1110, 32'hFFFF0000, 32'd10, 32'd0, 1'b0, 0, 1'b0);
      step(); step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_result_kept", ALUResult, 32'd30);
      repeat (15) step();

      // Flush while idle blocks the accept
      in_valid = 1'b1; flush = 1'b1; Operation = 4'b0010; SrcA = 32'd1; SrcB = 32'd1;
      step();
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_idle_in_ready", {31'd0, in_ready}, 32'd1);
      chk("flush_idle_out_valid", {31'd0, out_valid}, 32'd0);
      repeat (3) step();

      // Reset while a result is held in DONE
      out_ready = 1'b0;
      issue(4'b0011, 32'd1, 32'd1, 32'd0, 1'b1, 1, 1'b0);
      chk("pre_rst_taken", {31'd0, Taken}, 32'd1);
      rst_n = 1'b0;
      step();
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_result", ALUResult, 32'd0);
      chk("mid_rst_taken", {31'd0, Taken}, 32'd0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      issue(4'b0111, 32'd5, 32'd2, 32'd6, 1'b1, 1, 1'b1); // JALR
      wait_idle();
      repeat (3) step();
      chk("scoreboard_empty", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
